vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Timing generator directly upstream of the RGB blanking stage.
- Produces horizontal/vertical sync, the `active` (display-enable) flag, and the current pixel coordinates.
- The pixel-source logic uses `x`/`y` to compute the 2-bit `red_pixel`/`green_pixel`/`blue_pixel` values; the blanking stage gates that colour with `active` to form the 6-bit VGA bus.
- Default timing is 640x480@60 Hz with one pixel per enabled clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low, VGA default)

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous reset, active-high
- ce  in  1  pixel enable; counters advance only on clk edges with ce=1
- hsync  out  1  horizontal sync, asserted level = SYNC_POL
- vsync  out  1  vertical sync, asserted level = SYNC_POL
- active  out  1  1 when (x,y) lies inside the visible area
- x  out  10  current horizontal position, 0..H_TOTAL-1
- y  out  10  current vertical position, 0..V_TOTAL-1
- line_start  out  1  1 while x==0
- frame_start  out  1  1 while x==0 and y==0

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both must be <=1024; elaboration-time check fails otherwise.
- State is exactly two registered counters, x and y. All other outputs are combinational decodes of the registered counters, so they carry zero latency relative to x/y.
- Reset: on a clk edge with rst=1, x<=H_TOTAL-1 and y<=V_TOTAL-1 (799,524). This gives:
  - hsync = vsync = !SYNC_POL (deasserted)
  - active = 0
  - line_start = 0, frame_start = 0
- rst has priority over ce. Reset mid-frame returns to (H_TOTAL-1, V_TOTAL-1) on that edge regardless of position.
- Advance (rst=0, ce=1):
  - If x==H_TOTAL-1: x<=0, and y<=(y==V_TOTAL-1) ? 0 : y+1.
  - Else: x<=x+1, y unchanged.
- Hold (rst=0, ce=0): x and y unchanged, so all outputs hold. Level pulses (line_start, frame_start) therefore stretch for as many clocks as ce stays low.
- First enabled edge after reset release moves to (0,0): frame_start=1, line_start=1, active=1.
- active = (x < H_ACTIVE) && (y < V_ACTIVE).
- hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491). vsync is line-based: it changes only where x wraps to 0.
- Wrap-around: (799,524) -> (0,0) in one enabled edge; no extra idle cycle.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1 under any ce pattern.

Test Plan:
- Reset, then release with ce=1 tied -> during reset x=799, y=524, active=0, hsync=vsync=1. First edge after release -> x=0, y=0, frame_start=1, line_start=1, active=1.
- Free-run one line -> active falls at x=640. hsync low for exactly 96 clocks (x=656..751). At x=799->0, y increments 0->1 and line_start pulses for 1 clock.
- Free-run a full frame -> exactly 420000 clocks between frame_start pulses. vsync low for 1600 clocks starting at (0,490). active high for 307200 clocks total.
- ce toggled 1,0,0,1 repeatedly -> x advances only on ce=1 edges. Outputs hold while ce=0. The frame period becomes 420000 enabled edges.
- Assert rst for 1 clock at (300,200) -> next state (799,524). Next enabled edge -> (0,0) with frame_start=1.
- Re-parameterise SYNC_POL=1 with H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 ->
  - H_TOTAL=12, V_TOTAL=7
  - hsync=1 only at x=9..10
  - vsync=1 only at y=5
  - frame period 84 clocks

Source files
------------

// File: rtl/vga_sync_gen.sv
// Raster timing generator: two free-running pixel/line counters with combinational
// decodes for sync, display-enable and line/frame markers (zero latency vs x/y).
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  // 11-bit thresholds so a window edge equal to 1024 still compares correctly
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        h_in_sync;
  logic        v_in_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= H_LAST;
      y <= V_LAST;
    end else if (ce) begin
      if (x == H_LAST) begin
        x <= '0;
        y <= (y == V_LAST) ? '0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  assign x_ext       = {1'b0, x};
  assign y_ext       = {1'b0, y};
  assign h_in_sync   = (x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END);
  assign v_in_sync   = (y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END);

  assign hsync       = h_in_sync ? SYNC_POL : ~SYNC_POL;
  assign vsync       = v_in_sync ? SYNC_POL : ~SYNC_POL;
  assign active      = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
  assign line_start  = (x == 10'd0);
  assign frame_start = (x == 10'd0) && (y == 10'd0);

endmodule
